// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory fetch unit: fault codes, NOP encoding, response payload.
package imem_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        fault_e      fault;
        logic [31:0] instr;
    } rsp_t;

    localparam int unsigned RSP_W = $bits(rsp_t);

    // Misalignment wins over an out-of-range word index.
    function automatic fault_e classify(input logic [31:0] addr, input int unsigned idx_w);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ((addr >> (idx_w + 32'd2)) != 32'd0) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry in-order response FIFO; count doubles as the outstanding-request counter.
module imem_rsp_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head slot is only rewritten when the FIFO is empty, so dout holds while stalled.
    assign dout = slot[rd_ptr];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch unit: word memory read on the accept edge into a 2-deep response FIFO.
// Optional IMEM_LOAD_PORT_EN adds a synchronous word-write load port (ld_en/ld_idx/ld_data).
module imem_fetch
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [1:0]  rsp_fault,
    output logic [31:0] rsp_addr
`ifdef IMEM_LOAD_PORT_EN
    ,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH] = '{default: NOP_INSTR};

`ifdef IMEM_LOAD_PORT_EN
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end
`endif

    logic [IDX_W-1:0] idx;
    fault_e           fault;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    rsp_t             din;
    rsp_t             dout;

    assign idx       = req_addr[IDX_W+1:2];
    assign fault     = classify(req_addr, IDX_W);
    assign req_ready = !rst && !flush && (count != 2'd2);
    assign push      = req_valid && req_ready;
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready && !flush;

    // Memory word is captured into the FIFO on the accept edge; faults substitute NOP.
    always_comb begin
        din       = '0;
        din.addr  = req_addr;
        din.fault = fault;
        din.instr = (fault == FAULT_NONE) ? mem[idx] : NOP_INSTR;
    end

    imem_rsp_fifo #(
        .W (RSP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assign rsp_instr = dout.instr;
    assign rsp_fault = 2'(dout.fault);
    assign rsp_addr  = dout.addr;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: directed requests push expected responses, a monitor pops and compares.
module tb_imem_fetch;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic [31:0] rsp_addr;
`ifdef IMEM_LOAD_PORT_EN
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_data;
`endif

    imem_fetch #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .rsp_addr  (rsp_addr)
`ifdef IMEM_LOAD_PORT_EN
        ,
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && !flush && rsp_valid && rsp_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got addr %h instr %h fault %0d with nothing expected",
                         rsp_addr, rsp_instr, rsp_fault);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_addr !== e.addr || rsp_instr !== e.instr || rsp_fault !== e.fault) begin
                    n_err++;
                    $display("FAIL rsp_%h: got addr %h instr %h fault %0d expected addr %h instr %h fault %0d",
                             e.addr, rsp_addr, rsp_instr, rsp_fault, e.addr, e.instr, e.fault);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef,
                         output int waited);
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
        end else begin
            e.addr  = a;
            e.instr = ei;
            e.fault = ef;
            sb.push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            tick();
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses still expected", sb.size());
            sb.delete();
        end
    endtask

    task automatic preload(input int unsigned i, input logic [31:0] d);
`ifdef IMEM_LOAD_PORT_EN
        ld_en   = 1'b1;
        ld_idx  = 6'(i);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
`else
        dut.mem[i] = d;
`endif
    endtask

    initial begin
        int          w;
        logic [31:0] hold_instr;
        logic [31:0] hold_addr;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
        ld_en     = 1'b0;
        ld_idx    = '0;
        ld_data   = '0;
`endif
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_rsp_addr",  rsp_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        tick();

        preload(0, 32'h0000_0093);
        preload(1, 32'h0010_0113);
        preload(2, 32'h0020_0193);
        preload(3, 32'h1111_1111);
        preload(5, 32'h0001_A303);
        tick();

        // Single fetch, one-cycle response latency.
        rsp_ready = 1'b1;
        issue(32'h14, 32'h0001_A303, 2'd0, w);
        @(negedge clk);
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        drain();

        // Back-to-back at full rate.
        issue(32'h00, 32'h0000_0093, 2'd0, w);
        chk("b2b_wait0", 32'(w), 32'd0);
        issue(32'h04, 32'h0010_0113, 2'd0, w);
        chk("b2b_wait1", 32'(w), 32'd0);
        issue(32'h08, 32'h0020_0193, 2'd0, w);
        chk("b2b_wait2", 32'(w), 32'd0);
        drain();

        // Consumer stall: two accepted, third blocked, head held stable.
        rsp_ready = 1'b0;
        issue(32'h00, 32'h0000_0093, 2'd0, w);
        issue(32'h04, 32'h0010_0113, 2'd0, w);
        req_valid = 1'b1;
        req_addr  = 32'h08;
        @(negedge clk);
        chk("stall_ready_low", 32'(req_ready), 32'd0);
        hold_instr = rsp_instr;
        hold_addr  = rsp_addr;
        repeat (3) @(negedge clk);
        chk("stall_instr_hold", rsp_instr, hold_instr);
        chk("stall_addr_hold", rsp_addr, hold_addr);
        chk("stall_head_addr", rsp_addr, 32'h00);
        tick();
        rsp_ready = 1'b1;
        issue(32'h08, 32'h0020_0193, 2'd0, w);
        chk("stall_third_waited", 32'(w > 0), 32'd1);
        drain();

        // Faults and boundaries.
        issue(32'h06,  NOP, 2'd1, w);
        issue(32'h100, NOP, 2'd2, w);
        issue(32'h103, NOP, 2'd1, w);
        issue(32'hFC,  NOP, 2'd0, w);
        issue(32'h0C,  32'h1111_1111, 2'd0, w);
        drain();

        // Flush with two outstanding and a competing request.
        rsp_ready = 1'b0;
        issue(32'h00, 32'h0000_0093, 2'd0, w);
        issue(32'h04, 32'h0010_0113, 2'd0, w);
        req_valid = 1'b1;
        req_addr  = 32'h08;
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", 32'(req_ready), 32'd0);
        sb.delete();
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_outstanding", 32'(dut.u_fifo.count), 32'd0);
        repeat (3) @(negedge clk);
        chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        issue(32'h14, 32'h0001_A303, 2'd0, w);
        drain();

        // Reset mid-transfer drops pending responses but keeps memory.
        rsp_ready = 1'b0;
        issue(32'h00, 32'h0000_0093, 2'd0, w);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        issue(32'h14, 32'h0001_A303, 2'd0, w);
        drain();

`ifdef IMEM_LOAD_PORT_EN
        // Write and read of the same word in one cycle returns the old data.
        ld_en   = 1'b1;
        ld_idx  = 6'd3;
        ld_data = 32'hDEAD_BEEF;
        issue(32'h0C, 32'h1111_1111, 2'd0, w);
        ld_en   = 1'b0;
        issue(32'h0C, 32'hDEAD_BEEF, 2'd0, w);
        drain();
`endif

        repeat (2) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
